mac_learning_table: RTL and testbench

// - Source-address learning/forwarding table; consumes per-port mac_info_interface pulses from mac_source_parser.
// - Learns {source MAC -> ingress port} and answers destination lookups from the forwarding stage.
// - Fully associative register table with parallel compare; entries age out via a tick timer.

---
 rtl/mac_learning_table_pkg.sv | 39 +++
 rtl/mac_learning_table_rr_arbiter.sv | 49 ++++
 rtl/mac_learning_table.sv | 219 +++++++++++++++++++++
 tb/tb_mac_learning_table.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_learning_table_pkg.sv
// Shared types for the MAC learning table: address/entry layouts and address-class helpers.
// Pure declarations: no latency, no backpressure.
// Ingress learn interface is a valid-only pulse; it has no ready signal.
package mac_learning_table_pkg;

    localparam int MAC_W     = 48;
    localparam int MAX_PORTS = 4;
    localparam int PORT_W    = $clog2(MAX_PORTS);

    typedef logic [MAC_W-1:0] mac_addr_t;

    typedef struct packed {
        logic      mac_valid;
        mac_addr_t mac_number_per_port;
    } mac_info_t;

    typedef struct packed {
        logic              valid;
        logic              stale;
        logic [PORT_W-1:0] port;
        mac_addr_t         mac;
    } mac_entry_t;

    typedef enum logic [1:0] {
        LRN_IDLE,
        LRN_COMPARE,
        LRN_WRITE
    } lrn_state_t;

    // I/G bit: the LSB of the first octet on the wire.
    function automatic logic is_group_mac(input mac_addr_t mac);
        return mac[40];
    endfunction

    function automatic logic is_learnable_mac(input mac_addr_t mac);
        return !is_group_mac(mac) && (mac != '0);
    endfunction

endpackage

// File: rtl/mac_learning_table_rr_arbiter.sv
// Round-robin arbiter: one-hot grant plus index among N requesters.
// Latency: combinational grant; the pointer moves one cycle after an accepted grant.
// Backpressure: the grant is held until accept; the pointer advances past the granted requester only on accept.
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    input  logic          accept,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          grant_vld
);

    logic [IW-1:0]  ptr;
    logic [2*N-1:0] req_dbl;
    logic [N-1:0]   req_rot;
    logic [IW:0]    sum;

    // Rotate so that bit 0 is the requester at the pointer, then take the lowest set bit.
    always_comb begin
        req_dbl   = {req, req} >> ptr;
        req_rot   = req_dbl[N-1:0];
        grant_vld = |req;
        sum       = '0;
        for (int j = N - 1; j >= 0; j--) begin
            if (req_rot[j]) begin
                sum = {1'b0, ptr} + (IW+1)'(j);
            end
        end
        if (sum >= (IW+1)'(N)) begin
            sum = sum - (IW+1)'(N);
        end
        grant_idx        = sum[IW-1:0];
        grant            = '0;
        grant[grant_idx] = grant_vld;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (accept && grant_vld) begin
            ptr <= (grant_idx == IW'(N - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/mac_learning_table.sv
// Source-MAC learning table with parallel destination lookup and tick-based aging.
// Latency: lookup result 2 cycles after lookup_req; one learn at most every 3 cycles.
// Backpressure: none; a per-port holding register keeps only the newest MAC, and every discarded learn pulses learn_drop.
module mac_learning_table
    import mac_learning_table_pkg::*;
#(
    parameter  int NUM_PORTS = 4,
    parameter  int DEPTH     = 16,
    parameter  int AGE_TICKS = 125000000,
    localparam int PW        = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
    localparam int IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W     = $clog2(DEPTH + 1),
    localparam int AGE_W     = (AGE_TICKS > 1) ? $clog2(AGE_TICKS) : 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  mac_info_t [NUM_PORTS-1:0]   mac_info_in,
    input  logic                        lookup_req,
    input  mac_addr_t                   lookup_mac,
    input  logic                        age_enable,
    output logic                        lookup_valid,
    output logic                        lookup_hit,
    output logic [PW-1:0]               lookup_port,
    output logic                        learn_drop,
    output logic [CNT_W-1:0]            entry_count
);

    mac_entry_t           tbl [DEPTH];
    logic [NUM_PORTS-1:0] pend_vld;
    mac_addr_t            pend_mac [NUM_PORTS];
    logic [NUM_PORTS-1:0] new_vld;
    logic [NUM_PORTS-1:0] hold_drop;

    logic [NUM_PORTS-1:0] arb_grant;
    logic [PW-1:0]        arb_idx;
    logic                 arb_vld;
    logic                 take;

    lrn_state_t           state;
    logic [PW-1:0]        cur_port;
    mac_addr_t            cur_mac;
    logic                 cmp_hit, cmp_free;
    logic [IDX_W-1:0]     cmp_hit_idx, cmp_free_idx;
    logic                 hit_c, free_c;
    logic [IDX_W-1:0]     hit_idx_c, free_idx_c;

    logic [AGE_W-1:0]     age_cnt;
    logic                 tick;

    logic                 lk_vld_q;
    mac_addr_t            lk_mac_q;
    logic                 lk_hit_c;
    logic [PW-1:0]        lk_port_c;
    logic [CNT_W-1:0]     cnt_c;

    assign take = (state == LRN_IDLE) && arb_vld;
    assign tick = age_enable && (age_cnt == AGE_W'(AGE_TICKS - 1));

    rr_arbiter #(.N(NUM_PORTS)) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (pend_vld),
        .accept    (take),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .grant_vld (arb_vld)
    );

    // A port's register is only safe to overwrite silently in the cycle it is being granted.
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            new_vld[p]   = mac_info_in[p].mac_valid && is_learnable_mac(mac_info_in[p].mac_number_per_port);
            hold_drop[p] = new_vld[p] && pend_vld[p] && !(take && arb_grant[p]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_vld <= '0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                pend_mac[p] <= '0;
            end
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (take && arb_grant[p]) begin
                    pend_vld[p] <= 1'b0;
                end
                if (new_vld[p]) begin
                    pend_vld[p] <= 1'b1;
                    pend_mac[p] <= mac_info_in[p].mac_number_per_port;
                end
            end
        end
    end

    // Descending scan leaves the lowest matching/free index in the result.
    always_comb begin
        hit_c      = 1'b0;
        hit_idx_c  = '0;
        free_c     = 1'b0;
        free_idx_c = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (tbl[i].valid && (tbl[i].mac == cur_mac)) begin
                hit_c     = 1'b1;
                hit_idx_c = IDX_W'(i);
            end
            if (!tbl[i].valid) begin
                free_c     = 1'b1;
                free_idx_c = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= LRN_IDLE;
            cur_port     <= '0;
            cur_mac      <= '0;
            cmp_hit      <= 1'b0;
            cmp_free     <= 1'b0;
            cmp_hit_idx  <= '0;
            cmp_free_idx <= '0;
            learn_drop   <= 1'b0;
        end else begin
            learn_drop <= (|hold_drop) || ((state == LRN_WRITE) && !cmp_hit && !cmp_free);
            case (state)
                LRN_IDLE: begin
                    if (arb_vld) begin
                        cur_port <= arb_idx;
                        cur_mac  <= pend_mac[arb_idx];
                        state    <= LRN_COMPARE;
                    end
                end
                LRN_COMPARE: begin
                    cmp_hit      <= hit_c;
                    cmp_hit_idx  <= hit_idx_c;
                    cmp_free     <= free_c;
                    cmp_free_idx <= free_idx_c;
                    state        <= LRN_WRITE;
                end
                default: state <= LRN_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            age_cnt <= '0;
        end else if (age_enable) begin
            age_cnt <= tick ? '0 : age_cnt + 1'b1;
        end
    end

    // The learn write comes after the aging update so it wins on a shared entry; a hit
    // also re-asserts valid in case the entry expired between COMPARE and WRITE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (tick && tbl[i].valid) begin
                    if (tbl[i].stale) begin
                        tbl[i].valid <= 1'b0;
                    end else begin
                        tbl[i].stale <= 1'b1;
                    end
                end
            end
            if (state == LRN_WRITE) begin
                if (cmp_hit) begin
                    tbl[cmp_hit_idx].valid <= 1'b1;
                    tbl[cmp_hit_idx].stale <= 1'b0;
                    tbl[cmp_hit_idx].port  <= PORT_W'(cur_port);
                end else if (cmp_free) begin
                    tbl[cmp_free_idx] <= '{valid: 1'b1, stale: 1'b0, port: PORT_W'(cur_port), mac: cur_mac};
                end
            end
        end
    end

    always_comb begin
        lk_hit_c  = 1'b0;
        lk_port_c = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (tbl[i].valid && (tbl[i].mac == lk_mac_q) && !is_group_mac(lk_mac_q)) begin
                lk_hit_c  = 1'b1;
                lk_port_c = PW'(tbl[i].port);
            end
        end
    end

    always_comb begin
        cnt_c = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cnt_c = cnt_c + CNT_W'(tbl[i].valid);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lk_vld_q     <= 1'b0;
            lk_mac_q     <= '0;
            lookup_valid <= 1'b0;
            lookup_hit   <= 1'b0;
            lookup_port  <= '0;
            entry_count  <= '0;
        end else begin
            lk_vld_q     <= lookup_req;
            lk_mac_q     <= lookup_mac;
            lookup_valid <= lk_vld_q;
            lookup_hit   <= lk_vld_q && lk_hit_c;
            lookup_port  <= (lk_vld_q && lk_hit_c) ? lk_port_c : '0;
            entry_count  <= cnt_c;
        end
    end

endmodule

// File: tb/tb_mac_learning_table.sv
// Directed bench for mac_learning_table: learning, station move, overflow, arbitration order,
// aging and mid-operation reset, all against hand-computed expectations.
module tb_mac_learning_table;
    import mac_learning_table_pkg::*;

    localparam int NUM_PORTS = 4;
    localparam int DEPTH     = 16;
    localparam int AGE_TICKS = 16;

    localparam mac_addr_t MAC_A    = 48'h0011_2233_4455;
    localparam mac_addr_t MAC_B    = 48'h00AA_BB00_0001;
    localparam mac_addr_t MAC_C    = 48'h0A0B_0C0D_0E0F;
    localparam mac_addr_t MAC_MC   = 48'h0100_5E00_0001;
    localparam mac_addr_t MAC_BC   = 48'hFFFF_FFFF_FFFF;
    localparam mac_addr_t MAC_P    = 48'h0000_0000_1001;
    localparam mac_addr_t MAC_Q    = 48'h0000_0000_1002;
    localparam mac_addr_t MAC_R    = 48'h0000_0000_1003;
    localparam mac_addr_t MAC_BASE = 48'h0400_0000_0000;
    localparam mac_addr_t MAC_FILL = 48'h0200_0000_0100;

    logic                       clk = 1'b0;
    logic                       rst_n = 1'b0;
    mac_info_t [NUM_PORTS-1:0]  mac_info_in;
    logic                       lookup_req;
    mac_addr_t                  lookup_mac;
    logic                       age_enable;
    logic                       lookup_valid;
    logic                       lookup_hit;
    logic [1:0]                 lookup_port;
    logic                       learn_drop;
    logic [4:0]                 entry_count;

    int n_tests = 0;
    int n_fail  = 0;
    int drop_cnt = 0;
    int d0;
    logic seen;

    mac_learning_table #(
        .NUM_PORTS (NUM_PORTS),
        .DEPTH     (DEPTH),
        .AGE_TICKS (AGE_TICKS)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mac_info_in  (mac_info_in),
        .lookup_req   (lookup_req),
        .lookup_mac   (lookup_mac),
        .age_enable   (age_enable),
        .lookup_valid (lookup_valid),
        .lookup_hit   (lookup_hit),
        .lookup_port  (lookup_port),
        .learn_drop   (learn_drop),
        .entry_count  (entry_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (learn_drop) drop_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic learn(input int p, input mac_addr_t m);
        @(negedge clk);
        mac_info_in[p] = '{mac_valid: 1'b1, mac_number_per_port: m};
        @(negedge clk);
        mac_info_in[p].mac_valid = 1'b0;
    endtask

    task automatic lookup(input string tag, input mac_addr_t m, input logic exp_hit, input logic [1:0] exp_port);
        @(negedge clk);
        lookup_req = 1'b1;
        lookup_mac = m;
        @(negedge clk);
        lookup_req = 1'b0;
        chk({tag, "_early"}, 64'(lookup_valid), 64'd0);
        @(negedge clk);
        chk({tag, "_vld"}, 64'(lookup_valid), 64'd1);
        chk({tag, "_hit"}, 64'(lookup_hit), 64'(exp_hit));
        chk({tag, "_port"}, 64'(lookup_port), 64'(exp_port));
    endtask

    task automatic wait_count(input string tag, input int exp, input int budget);
        int k = 0;
        while ((int'(entry_count) != exp) && (k < budget)) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 64'(entry_count), 64'(exp));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n       = 1'b0;
        mac_info_in = '0;
        lookup_req  = 1'b0;
        age_enable  = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
    endtask

    initial begin
        mac_info_in = '0;
        lookup_req  = 1'b0;
        lookup_mac  = '0;
        age_enable  = 1'b0;
        cyc(3);
        chk("rst_vld", 64'(lookup_valid), 64'd0);
        chk("rst_hit", 64'(lookup_hit), 64'd0);
        chk("rst_port", 64'(lookup_port), 64'd0);
        chk("rst_drop", 64'(learn_drop), 64'd0);
        chk("rst_cnt", 64'(entry_count), 64'd0);
        rst_n = 1'b1;
        cyc(2);

        // Basic learn on port 2, lookup 10 cycles later.
        learn(2, MAC_A);
        cyc(10);
        lookup("lrn_p2", MAC_A, 1'b1, 2'd2);
        chk("lrn_cnt", 64'(entry_count), 64'd1);

        // Station move to port 0.
        learn(0, MAC_A);
        cyc(6);
        chk("move_cnt", 64'(entry_count), 64'd1);
        lookup("move", MAC_A, 1'b1, 2'd0);

        // Group and all-zero sources are ignored without a drop.
        d0 = drop_cnt;
        learn(3, MAC_MC);
        learn(3, 48'h0);
        cyc(6);
        chk("grp_cnt", 64'(entry_count), 64'd1);
        chk("grp_drop", 64'(drop_cnt - d0), 64'd0);
        lookup("grp_lk", MAC_MC, 1'b0, 2'd0);
        lookup("unk_lk", MAC_B, 1'b0, 2'd0);

        // Back-to-back lookups: known then unknown.
        @(negedge clk);
        lookup_req = 1'b1;
        lookup_mac = MAC_A;
        @(negedge clk);
        lookup_mac = MAC_B;
        @(negedge clk);
        lookup_req = 1'b0;
        chk("b2b_vld0", 64'(lookup_valid), 64'd1);
        chk("b2b_hit0", 64'(lookup_hit), 64'd1);
        chk("b2b_port0", 64'(lookup_port), 64'd0);
        @(negedge clk);
        chk("b2b_vld1", 64'(lookup_valid), 64'd1);
        chk("b2b_hit1", 64'(lookup_hit), 64'd0);
        @(negedge clk);
        chk("b2b_idle", 64'(lookup_valid), 64'd0);

        // Three pulses on one port in consecutive cycles: middle one is granted-cycle load,
        // third overwrites a pending entry and is the only drop.
        d0 = drop_cnt;
        @(negedge clk);
        mac_info_in[1] = '{mac_valid: 1'b1, mac_number_per_port: MAC_P};
        @(negedge clk);
        mac_info_in[1].mac_number_per_port = MAC_Q;
        @(negedge clk);
        mac_info_in[1].mac_number_per_port = MAC_R;
        @(negedge clk);
        mac_info_in[1].mac_valid = 1'b0;
        cyc(10);
        chk("ovw_cnt", 64'(entry_count), 64'd3);
        chk("ovw_drop", 64'(drop_cnt - d0), 64'd1);
        lookup("ovw_q", MAC_Q, 1'b0, 2'd0);
        lookup("ovw_r", MAC_R, 1'b1, 2'd1);

        // All four ports at once after reset: learned in port order, no drop.
        do_reset();
        d0 = drop_cnt;
        @(negedge clk);
        for (int p = 0; p < NUM_PORTS; p++) begin
            mac_info_in[p] = '{mac_valid: 1'b1, mac_number_per_port: MAC_BASE + 48'(p)};
        end
        @(negedge clk);
        for (int p = 0; p < NUM_PORTS; p++) begin
            mac_info_in[p].mac_valid = 1'b0;
        end
        wait_count("all4_cnt", 4, 13);
        chk("all4_drop", 64'(drop_cnt - d0), 64'd0);
        for (int p = 0; p < NUM_PORTS; p++) begin
            lookup("all4_lk", MAC_BASE + 48'(p), 1'b1, 2'(p));
        end

        // Same MAC on all ports: grant order 0..3 leaves port 3 as the final owner.
        @(negedge clk);
        for (int p = 0; p < NUM_PORTS; p++) begin
            mac_info_in[p] = '{mac_valid: 1'b1, mac_number_per_port: MAC_C};
        end
        @(negedge clk);
        for (int p = 0; p < NUM_PORTS; p++) begin
            mac_info_in[p].mac_valid = 1'b0;
        end
        cyc(14);
        chk("order_cnt", 64'(entry_count), 64'd5);
        lookup("order_lk", MAC_C, 1'b1, 2'd3);

        // DEPTH+1 distinct MACs on port 1.
        do_reset();
        d0 = drop_cnt;
        for (int i = 0; i <= DEPTH; i++) begin
            learn(1, MAC_FILL + 48'(i));
            cyc(3);
        end
        cyc(4);
        chk("full_cnt", 64'(entry_count), 64'(DEPTH));
        chk("full_drop", 64'(drop_cnt - d0), 64'd1);
        lookup("full_last", MAC_FILL + 48'(DEPTH), 1'b0, 2'd0);
        lookup("full_first", MAC_FILL, 1'b1, 2'd1);

        // Aging: stale at the 16th enabled edge, invalid at the 32nd, count lags one cycle.
        do_reset();
        learn(1, MAC_A);
        wait_count("age_cnt1", 1, 8);
        @(negedge clk);
        age_enable = 1'b1;
        cyc(20);
        chk("age_mid", 64'(entry_count), 64'd1);
        cyc(14);
        chk("age_gone", 64'(entry_count), 64'd0);

        // Refresh every 8 cycles keeps the entry across several tick periods.
        learn(1, MAC_A);
        for (int r = 0; r < 8; r++) begin
            learn(1, MAC_A);
            cyc(6);
        end
        chk("refresh_cnt", 64'(entry_count), 64'd1);
        lookup("refresh_lk", MAC_A, 1'b1, 2'd1);
        lookup("bcast_lk", MAC_BC, 1'b0, 2'd0);
        age_enable = 1'b0;

        // Reset during WRITE with a lookup in flight.
        do_reset();
        @(negedge clk);
        mac_info_in[0] = '{mac_valid: 1'b1, mac_number_per_port: MAC_A};
        @(negedge clk);
        mac_info_in[0].mac_valid = 1'b0;
        @(negedge clk);
        lookup_req = 1'b1;
        lookup_mac = MAC_A;
        @(negedge clk);
        lookup_req = 1'b0;
        rst_n      = 1'b0;
        seen       = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (lookup_valid) seen = 1'b1;
        end
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (lookup_valid) seen = 1'b1;
        end
        chk("midrst_vld", 64'(seen), 64'd0);
        chk("midrst_cnt", 64'(entry_count), 64'd0);
        lookup("midrst_lk", MAC_A, 1'b0, 2'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
